// File: rtl/clock_divider_prog.sv
// Multi-channel run-time programmable clock divider: each channel emits a 50% square wave
// plus a one-cycle tick on every rising edge. Define CLKDIV_SYNC_EN to add the sync_clr input.
module clock_divider_prog #(
  parameter int N_CH       = 4,
  parameter int DIV_W      = 16,
  parameter int INPUT_HZ   = 100_000_000,
  parameter int DEFAULT_HZ = 1_000,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic [N_CH-1:0]   clk_out,
  output logic [N_CH-1:0]   tick,
  output logic [N_CH-1:0]   pending
`ifdef CLKDIV_SYNC_EN
  ,
  input  logic              sync_clr
`endif
);

  localparam int DEFAULT_DIV = (INPUT_HZ / DEFAULT_HZ) / 2;

  if (DEFAULT_DIV >= (1 << DIV_W)) begin : g_bad_default
    $error("clock_divider_prog: DEFAULT_DIV does not fit in DIV_W bits");
  end

  logic syncClr;
`ifdef CLKDIV_SYNC_EN
  assign syncClr = sync_clr;
`else
  assign syncClr = 1'b0;
`endif

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] divAct_q, divAct_d;
    logic [DIV_W-1:0] divPend_q, divPend_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             wrHit, stopped, boundary;
    logic [DIV_W-1:0] newDiv;

    assign wrHit    = cfg_wr && (cfg_ch == CH_W'(g));
    assign stopped  = (divAct_q == '0);
    assign boundary = !stopped && (cnt_q == divAct_q - DIV_W'(1));
    // A write landing on the same cycle as a reload point beats an older pending value.
    assign newDiv   = wrHit ? cfg_div : (pend_q ? divPend_q : divAct_q);

    always_comb begin
      cnt_d     = cnt_q + DIV_W'(1);
      divAct_d  = divAct_q;
      divPend_d = divPend_q;
      pend_d    = pend_q;
      clk_d     = clk_q;
      tick_d    = 1'b0;
      if (syncClr || stopped) begin
        cnt_d    = '0;
        clk_d    = 1'b0;
        divAct_d = newDiv;
        pend_d   = 1'b0;
      end else if (boundary) begin
        cnt_d    = '0;
        divAct_d = newDiv;
        pend_d   = 1'b0;
        if (newDiv == '0) begin
          clk_d = 1'b0;
        end else begin
          clk_d  = ~clk_q;
          tick_d = ~clk_q;
        end
      end else if (wrHit) begin
        divPend_d = cfg_div;
        pend_d    = 1'b1;
      end
    end

    always_ff @(posedge clk_in) begin
      if (!rst_n) begin
        cnt_q     <= '0;
        divAct_q  <= DIV_W'(DEFAULT_DIV);
        divPend_q <= '0;
        pend_q    <= 1'b0;
        clk_q     <= 1'b0;
        tick_q    <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        divAct_q  <= divAct_d;
        divPend_q <= divPend_d;
        pend_q    <= pend_d;
        clk_q     <= clk_d;
        tick_q    <= tick_d;
      end
    end

    assign clk_out[g] = clk_q;
    assign tick[g]    = tick_q;
    assign pending[g] = pend_q;
  end

endmodule

// File: tb/tb_clock_divider_prog.sv
// Self-checking bench for clock_divider_prog: a directed vector table, randomized traffic
// against a deadline-based reference model, and hand-written multi-cycle corner sequences.
module tb_clock_divider_prog;

  localparam int N_CH       = 3;
  localparam int DIV_W      = 8;
  localparam int INPUT_HZ   = 8000;
  localparam int DEFAULT_HZ = 1000;
  localparam int DEF_DIV    = 4;

  logic             clk = 1'b0;
  logic             rstN = 1'b0;
  logic             cfgWr = 1'b0;
  logic [1:0]       cfgCh = '0;
  logic [DIV_W-1:0] cfgDiv = '0;
  logic             syncClr = 1'b0;
  logic [N_CH-1:0]  clkOut, tick, pending;

  int passCount = 0;
  int checkCount = 0;

  clock_divider_prog #(
    .N_CH(N_CH), .DIV_W(DIV_W), .INPUT_HZ(INPUT_HZ), .DEFAULT_HZ(DEFAULT_HZ)
  ) dut (
    .clk_in(clk), .rst_n(rstN), .cfg_wr(cfgWr), .cfg_ch(cfgCh), .cfg_div(cfgDiv),
    .clk_out(clkOut), .tick(tick), .pending(pending)
`ifdef CLKDIV_SYNC_EN
    , .sync_clr(syncClr)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: each channel tracks the absolute cycle of its next half-period end.
  longint cyc = 0;
  int     mDiv[N_CH], mPdiv[N_CH];
  longint mNext[N_CH];
  bit     mPend[N_CH], mLvl[N_CH], mTick[N_CH];

  always @(posedge clk) begin
    cyc++;
    for (int c = 0; c < N_CH; c++) begin
      bit hit;
      int nd;
      hit = cfgWr && (int'(cfgCh) == c);
      nd  = hit ? int'(cfgDiv) : (mPend[c] ? mPdiv[c] : mDiv[c]);
      if (!rstN) begin
        mDiv[c] = DEF_DIV; mPend[c] = 0; mLvl[c] = 0; mTick[c] = 0; mNext[c] = cyc + DEF_DIV;
      end else if (syncClr || mDiv[c] == 0) begin
        mDiv[c] = nd; mPend[c] = 0; mLvl[c] = 0; mTick[c] = 0; mNext[c] = cyc + nd;
      end else if (cyc == mNext[c]) begin
        mDiv[c]  = nd;
        mPend[c] = 0;
        mTick[c] = (nd != 0) && !mLvl[c];
        mLvl[c]  = (nd != 0) && !mLvl[c];
        mNext[c] = cyc + nd;
      end else begin
        mTick[c] = 0;
        if (hit) begin
          mPdiv[c] = int'(cfgDiv);
          mPend[c] = 1;
        end
      end
    end
  end

  typedef struct {
    logic             rstN;
    logic             wr;
    logic [1:0]       ch;
    logic [DIV_W-1:0] div;
    logic [N_CH-1:0]  expClk, expTick, expPend;
  } vec_t;

  vec_t vecs[14];

  task automatic checkOutput(input string name, input logic [N_CH-1:0] eClk,
                             input logic [N_CH-1:0] eTick, input logic [N_CH-1:0] ePend);
    checkCount++;
    if (clkOut === eClk && tick === eTick && pending === ePend) passCount++;
    else $display("[TB] FAIL %s @%0t: clk_out=%b tick=%b pending=%b, expected %b %b %b",
                  name, $time, clkOut, tick, pending, eClk, eTick, ePend);
  endtask

  task automatic checkValue(input string name, input int got, input int exp);
    checkCount++;
    if (got == exp) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic modelCheck(input string name);
    logic [N_CH-1:0] eClk, eTick, ePend;
    for (int c = 0; c < N_CH; c++) begin
      eClk[c] = mLvl[c]; eTick[c] = mTick[c]; ePend[c] = mPend[c];
    end
    checkOutput(name, eClk, eTick, ePend);
  endtask

  task automatic applyStimulus(input vec_t v);
    rstN = v.rstN; cfgWr = v.wr; cfgCh = v.ch; cfgDiv = v.div;
    @(negedge clk);
  endtask

  // Waits for clk_out[ch] to reach lvl; n counts sampling points until it does.
  task automatic waitLevel(input int ch, input logic lvl, input int maxN, output int n);
    n = 0;
    do begin
      @(negedge clk);
      cfgWr = 1'b0;
      n++;
      modelCheck("wait");
    end while (clkOut[ch] !== lvl && n < maxN);
    if (clkOut[ch] !== lvl) begin
      checkCount++;
      $display("[TB] FAIL waitLevel ch%0d: still %b after %0d cycles, expected %b", ch, clkOut[ch], n, lvl);
    end
  endtask

  initial begin
    int n;
    vecs[0]  = '{1'b0, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000};
    vecs[1]  = '{1'b0, 1'b1, 2'd0, 8'd2, 3'b000, 3'b000, 3'b000};
    vecs[2]  = '{1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000};
    vecs[3]  = '{1'b1, 1'b1, 2'd1, 8'd2, 3'b000, 3'b000, 3'b010};
    vecs[4]  = '{1'b1, 1'b1, 2'd3, 8'd5, 3'b000, 3'b000, 3'b010};
    vecs[5]  = '{1'b1, 1'b1, 2'd2, 8'd1, 3'b111, 3'b111, 3'b000};
    vecs[6]  = '{1'b1, 1'b1, 2'd0, 8'd0, 3'b011, 3'b000, 3'b001};
    vecs[7]  = '{1'b1, 1'b0, 2'd0, 8'd0, 3'b101, 3'b100, 3'b001};
    vecs[8]  = '{1'b1, 1'b0, 2'd0, 8'd0, 3'b001, 3'b000, 3'b001};
    vecs[9]  = '{1'b1, 1'b0, 2'd0, 8'd0, 3'b110, 3'b110, 3'b000};
    vecs[10] = '{1'b1, 1'b1, 2'd0, 8'd1, 3'b010, 3'b000, 3'b000};
    vecs[11] = '{1'b1, 1'b1, 2'd2, 8'd0, 3'b001, 3'b001, 3'b000};
    vecs[12] = '{1'b1, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000};
    vecs[13] = '{1'b1, 1'b0, 2'd0, 8'd0, 3'b011, 3'b011, 3'b000};

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].expClk, vecs[i].expTick, vecs[i].expPend);
    end

    for (int i = 0; i < 4000; i++) begin
      rstN   = ($urandom_range(0, 299) != 0);
      cfgWr  = ($urandom_range(0, 3) == 0);
      cfgCh  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) cfgDiv = DIV_W'($urandom_range(7, 40));
      else if ($urandom_range(0, 5) == 0) cfgDiv = '0;
      else cfgDiv = DIV_W'($urandom_range(1, 6));
`ifdef CLKDIV_SYNC_EN
      syncClr = ($urandom_range(0, 99) == 0);
`endif
      @(negedge clk);
      modelCheck("random");
    end
    rstN = 1'b1; cfgWr = 1'b0; syncClr = 1'b0;

    // Mid-half-period reprogram: old half-period must finish before the new ratio applies.
    cfgCh = 2'd1; cfgDiv = 8'd20; cfgWr = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      cfgWr = 1'b0;
      n++;
      modelCheck("reload20");
    end while (pending[1] !== 1'b0 && n < 100);
    checkValue("reload20 pending cleared", int'(pending[1]), 0);
    waitLevel(1, 1'b0, 100, n);
    waitLevel(1, 1'b1, 100, n);
    repeat (10) begin
      @(negedge clk);
      modelCheck("count10");
    end
    cfgCh = 2'd1; cfgDiv = 8'd3; cfgWr = 1'b1;
    waitLevel(1, 1'b0, 40, n);
    checkValue("old high half intact", n, 10);
    waitLevel(1, 1'b1, 40, n);
    checkValue("new low half", n, 3);
    waitLevel(1, 1'b0, 40, n);
    checkValue("new high half", n, 3);

`ifdef CLKDIV_SYNC_EN
    begin
      int firstRise[N_CH];
      syncClr = 1'b1; cfgWr = 1'b1;
      for (int c = 0; c < N_CH; c++) begin
        cfgCh  = 2'(c);
        cfgDiv = (c == 0) ? 8'd2 : (c == 1) ? 8'd3 : 8'd5;
        @(negedge clk);
        modelCheck("syncWrite");
      end
      syncClr = 1'b0; cfgWr = 1'b0;
      checkOutput("sync cleared", 3'b000, 3'b000, 3'b000);
      for (int c = 0; c < N_CH; c++) firstRise[c] = -1;
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        modelCheck("syncRun");
        for (int c = 0; c < N_CH; c++)
          if (firstRise[c] < 0 && clkOut[c] === 1'b1) firstRise[c] = k;
      end
      checkValue("sync ch0 rise", firstRise[0], 2);
      checkValue("sync ch1 rise", firstRise[1], 3);
      checkValue("sync ch2 rise", firstRise[2], 5);
    end
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
